// File: rtl/regfile_wb_sched_pkg.sv
// Shared encodings for the register-file write-back scheduler.
// prio values and grant-vector bit positions use the same source encoding.
package regfile_wb_sched_pkg;

  localparam logic WB_SRC_MEM = 1'b0;
  localparam logic WB_SRC_EX  = 1'b1;

  // Indexed by WB_SRC_*; at most one bit set.
  typedef logic [1:0] wb_gnt_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter between execute and memory write-back sources.
// Each grant hands priority to the source that was not granted.
module rr_arbiter2
  import regfile_wb_sched_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    i_ex_valid,
  input  logic    i_mem_valid,
  output wb_gnt_t o_gnt
);

  logic r_prio;

  always_comb begin
    o_gnt             = '0;
    o_gnt[WB_SRC_EX]  = i_ex_valid  & (~i_mem_valid | (r_prio == WB_SRC_EX));
    o_gnt[WB_SRC_MEM] = i_mem_valid & (~i_ex_valid  | (r_prio == WB_SRC_MEM));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prio <= WB_SRC_MEM;
    end else if (o_gnt[WB_SRC_EX]) begin
      r_prio <= WB_SRC_MEM;
    end else if (o_gnt[WB_SRC_MEM]) begin
      r_prio <= WB_SRC_EX;
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: arbitrates the register file's single write port and
// tracks per-register pending writes so decode can detect RAW/WAW hazards.
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int unsigned BIT_WIDTH    = 32,
  parameter int unsigned REG_COUNT_L2 = 4,
  parameter int unsigned REG_PC_INDEX = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    issue_valid,
  input  logic [REG_COUNT_L2-1:0] issue_addr,
  output logic                    issue_ready,
  input  logic [REG_COUNT_L2-1:0] chk_addr1,
  input  logic [REG_COUNT_L2-1:0] chk_addr2,
  output logic                    chk_hazard,
  input  logic                    ex_valid,
  input  logic [REG_COUNT_L2-1:0] ex_addr,
  input  logic [BIT_WIDTH-1:0]    ex_value,
  output logic                    ex_ready,
  input  logic                    mem_valid,
  input  logic [REG_COUNT_L2-1:0] mem_addr,
  input  logic [BIT_WIDTH-1:0]    mem_value,
  output logic                    mem_ready,
  output logic                    write_enable1,
  output logic [REG_COUNT_L2-1:0] write_addr1,
  output logic [BIT_WIDTH-1:0]    write_value1,
  output logic                    busy
);

  localparam int unsigned REG_COUNT = 1 << REG_COUNT_L2;
  localparam logic [REG_COUNT_L2-1:0] PC_ADDR = REG_COUNT_L2'(REG_PC_INDEX);

  wb_gnt_t                 w_gnt;
  logic                    w_gnt_any;
  logic [REG_COUNT_L2-1:0] w_waddr;
  logic [BIT_WIDTH-1:0]    w_wvalue;
  logic [REG_COUNT-1:0]    r_pending;
  logic [REG_COUNT-1:0]    w_pending_d;

  rr_arbiter2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .i_ex_valid  (ex_valid),
    .i_mem_valid (mem_valid),
    .o_gnt       (w_gnt)
  );

  assign ex_ready  = w_gnt[WB_SRC_EX];
  assign mem_ready = w_gnt[WB_SRC_MEM];
  assign w_gnt_any = |w_gnt;
  assign w_waddr   = w_gnt[WB_SRC_EX] ? ex_addr  : mem_addr;
  assign w_wvalue  = w_gnt[WB_SRC_EX] ? ex_value : mem_value;

  assign issue_ready = (issue_addr == PC_ADDR) | ~r_pending[issue_addr];
  // No same-cycle clear bypass: a register being written this cycle still reads as pending.
  assign chk_hazard  = r_pending[chk_addr1] | r_pending[chk_addr2];
  assign busy        = |r_pending;

  always_comb begin
    w_pending_d = r_pending;
    if (w_gnt_any) begin
      w_pending_d[w_waddr] = 1'b0;
    end
    if (flush) begin
      w_pending_d = '0;
    end else if (issue_valid && issue_ready) begin
      w_pending_d[issue_addr] = 1'b1;
    end
    w_pending_d[PC_ADDR] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_enable1 <= 1'b0;
      write_addr1   <= '0;
      write_value1  <= '0;
    end else begin
      write_enable1 <= w_gnt_any;
      if (w_gnt_any) begin
        write_addr1  <= w_waddr;
        write_value1 <= w_wvalue;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: a behavioural model checked every cycle,
// plus hand-computed literal expectations along the directed scenarios.
module tb_regfile_wb_sched;

  localparam int PC = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        issue_valid;
  logic [3:0]  issue_addr;
  logic        issue_ready;
  logic [3:0]  chk_addr1;
  logic [3:0]  chk_addr2;
  logic        chk_hazard;
  logic        ex_valid;
  logic [3:0]  ex_addr;
  logic [31:0] ex_value;
  logic        ex_ready;
  logic        mem_valid;
  logic [3:0]  mem_addr;
  logic [31:0] mem_value;
  logic        mem_ready;
  logic        write_enable1;
  logic [3:0]  write_addr1;
  logic [31:0] write_value1;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wb_sched dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_addr    (issue_addr),
    .issue_ready   (issue_ready),
    .chk_addr1     (chk_addr1),
    .chk_addr2     (chk_addr2),
    .chk_hazard    (chk_hazard),
    .ex_valid      (ex_valid),
    .ex_addr       (ex_addr),
    .ex_value      (ex_value),
    .ex_ready      (ex_ready),
    .mem_valid     (mem_valid),
    .mem_addr      (mem_addr),
    .mem_value     (mem_value),
    .mem_ready     (mem_ready),
    .write_enable1 (write_enable1),
    .write_addr1   (write_addr1),
    .write_value1  (write_value1),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: set of pending registers, favoured source, last write.
  bit          m_pend[16];
  bit          m_fav_ex = 1'b0;
  bit          m_we = 1'b0;
  logic [3:0]  m_waddr = '0;
  logic [31:0] m_wval = '0;
  bit          m_gex;
  bit          m_gmem;
  bit          m_iready;

  function automatic bit model_gnt_ex();
    return ex_valid && (!mem_valid || m_fav_ex);
  endfunction

  function automatic bit model_gnt_mem();
    return mem_valid && (!ex_valid || !m_fav_ex);
  endfunction

  function automatic bit model_busy();
    for (int i = 0; i < 16; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
        m_fav_ex = 1'b0;
        m_we     = 1'b0;
        m_waddr  = '0;
        m_wval   = '0;
      end else begin
        m_gex    = model_gnt_ex();
        m_gmem   = model_gnt_mem();
        m_iready = (issue_addr == PC) || !m_pend[issue_addr];
        m_we     = m_gex || m_gmem;
        if (m_gex) begin
          m_waddr = ex_addr;  m_wval = ex_value;  m_fav_ex = 1'b0;
          m_pend[ex_addr] = 1'b0;
        end else if (m_gmem) begin
          m_waddr = mem_addr; m_wval = mem_value; m_fav_ex = 1'b1;
          m_pend[mem_addr] = 1'b0;
        end
        if (flush) begin
          for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
        end else if (issue_valid && m_iready && issue_addr != PC) begin
          m_pend[issue_addr] = 1'b1;
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("m_ex_ready",    ex_ready,      model_gnt_ex());
      check("m_mem_ready",   mem_ready,     model_gnt_mem());
      check("m_issue_ready", issue_ready,   (issue_addr == PC) || !m_pend[issue_addr]);
      check("m_chk_hazard",  chk_hazard,    m_pend[chk_addr1] || m_pend[chk_addr2]);
      check("m_busy",        busy,          model_busy());
      check("m_we",          write_enable1, m_we);
      check("m_waddr",       write_addr1,   m_waddr);
      check("m_wval",        write_value1,  m_wval);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; issue_valid = 0; ex_valid = 0; mem_valid = 0;
  endtask

  logic [3:0]  t1_ex_a[4]  = '{4, 4, 5, 5};
  logic [3:0]  t1_mem_a[4] = '{8, 9, 9, 10};
  logic [3:0]  t1_wa[4]    = '{8, 4, 9, 5};
  logic [31:0] t1_wv[4]    = '{32'hA8, 32'hE4, 32'hA9, 32'hE5};
  logic [3:0]  t1_mem_gnt  = 4'b0101;

  initial begin
    reset = 1; idle();
    issue_addr = 0; chk_addr1 = 0; chk_addr2 = 0;
    ex_addr = 0; ex_value = 0; mem_addr = 0; mem_value = 0;
    @(negedge clk);
    check("rst_we", write_enable1, 0);
    check("rst_busy", busy, 0);
    check("rst_issue_ready", issue_ready, 1);
    check("rst_hazard", chk_hazard, 0);
    @(posedge clk); #1;
    reset = 0;

    // Contention: mem, ex, mem, ex.
    for (int i = 0; i < 4; i++) begin
      ex_valid = 1; mem_valid = 1;
      ex_addr = t1_ex_a[i];   ex_value = 32'hE0 + 32'(t1_ex_a[i]);
      mem_addr = t1_mem_a[i]; mem_value = 32'hA0 + 32'(t1_mem_a[i]);
      @(negedge clk);
      check("t1_mem_gnt", mem_ready, t1_mem_gnt[i]);
      check("t1_ex_gnt", ex_ready, !t1_mem_gnt[i]);
      if (i > 0) begin
        check("t1_we", write_enable1, 1);
        check("t1_waddr", write_addr1, t1_wa[i-1]);
        check("t1_wval", write_value1, t1_wv[i-1]);
      end
      tick();
    end
    idle();
    @(negedge clk);
    check("t1_waddr_last", write_addr1, 5);
    check("t1_wval_last", write_value1, 32'hE5);
    tick();

    // RAW on r3, cleared by an ex write.
    issue_valid = 1; issue_addr = 3;
    tick();
    idle(); chk_addr1 = 3; chk_addr2 = 0;
    @(negedge clk);
    check("t2_hazard", chk_hazard, 1);
    check("t2_issue_ready", issue_ready, 0);
    check("t2_busy", busy, 1);
    tick();
    ex_valid = 1; ex_addr = 3; ex_value = 32'hDEADBEEF;
    @(negedge clk);
    check("t2_ex_ready", ex_ready, 1);
    check("t2_hazard_nobypass", chk_hazard, 1);
    tick();
    idle();
    @(negedge clk);
    check("t2_we", write_enable1, 1);
    check("t2_waddr", write_addr1, 3);
    check("t2_wval", write_value1, 32'hDEADBEEF);
    check("t2_hazard_clr", chk_hazard, 0);
    tick();

    // PC index is never tracked.
    issue_valid = 1; issue_addr = 15;
    tick();
    idle(); chk_addr1 = 15;
    ex_valid = 1; ex_addr = 15; ex_value = 32'h15;
    @(negedge clk);
    check("t3_busy", busy, 0);
    check("t3_hazard", chk_hazard, 0);
    check("t3_issue_ready", issue_ready, 1);
    tick();
    idle();
    @(negedge clk);
    check("t3_we", write_enable1, 1);
    check("t3_waddr", write_addr1, 15);
    tick();

    // Flush drops pending bits and same-cycle issue, not the grant.
    issue_valid = 1; issue_addr = 1; tick();
    issue_addr = 2; tick();
    issue_addr = 4; tick();
    idle(); chk_addr1 = 1; chk_addr2 = 4;
    @(negedge clk);
    check("t4_busy_pre", busy, 1);
    check("t4_hazard_pre", chk_hazard, 1);
    tick();
    flush = 1; issue_valid = 1; issue_addr = 5;
    mem_valid = 1; mem_addr = 7; mem_value = 32'h77;
    @(negedge clk);
    check("t4_mem_ready", mem_ready, 1);
    tick();
    idle(); chk_addr1 = 5; chk_addr2 = 1;
    @(negedge clk);
    check("t4_busy", busy, 0);
    check("t4_hazard", chk_hazard, 0);
    check("t4_issue_ready", issue_ready, 1);
    check("t4_we", write_enable1, 1);
    check("t4_waddr", write_addr1, 7);
    tick();

    // Reset right after a mem grant.
    mem_valid = 1; mem_addr = 9; mem_value = 32'h99;
    tick();
    idle();
    check("t5_we_before", write_enable1, 1);
    reset = 1;
    #1;
    check("t5_we_async", write_enable1, 0);
    tick();
    tick();
    reset = 0;
    @(negedge clk);
    check("t5_no_spurious", write_enable1, 0);
    tick();
    ex_valid = 1; ex_addr = 11; ex_value = 32'hB;
    mem_valid = 1; mem_addr = 12; mem_value = 32'hC;
    @(negedge clk);
    check("t5_mem_favoured", mem_ready, 1);
    check("t5_ex_waits", ex_ready, 0);
    tick();
    idle();
    @(negedge clk);
    check("t5_waddr", write_addr1, 12);
    tick();

    // Lone ex requester gets back-to-back grants.
    for (int i = 0; i < 3; i++) begin
      ex_valid = 1; ex_addr = 4'(10 + i); ex_value = 32'h100 + 32'(i);
      @(negedge clk);
      check("t6_ex_ready", ex_ready, 1);
      if (i > 0) begin
        check("t6_we", write_enable1, 1);
        check("t6_waddr", write_addr1, 32'(10 + i - 1));
      end
      tick();
    end
    idle();
    @(negedge clk);
    check("t6_we_last", write_enable1, 1);
    check("t6_wval_last", write_value1, 32'h102);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-back scheduler for the register file's single write port. It arbitrates round-robin between the execute-stage and memory-stage write-back requesters, registers the winner onto `write_enable1`/`write_addr1`/`write_value1`, and keeps a per-register pending scoreboard so decode can detect RAW and WAW hazards. It sits between the pipeline's write-back sources and the register file.

## Interface
Parameters:
- `BIT_WIDTH`, 32: data width.
- `REG_COUNT_L2`, 4: register address width; register count is 2^REG_COUNT_L2.
- `REG_PC_INDEX`, 15: PC register index. It is never tracked and never reports a hazard.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  clears every pending bit (mispredict).
- `issue_valid`  in  1  decode marks `issue_addr` pending.
- `issue_addr`  in  REG_COUNT_L2  destination of the issuing instruction.
- `issue_ready`  out  1  `!pending[issue_addr]`; the PC index is always 1.
- `chk_addr1`, `chk_addr2`  in  REG_COUNT_L2  decode source registers.
- `chk_hazard`  out  1  high if either source is pending.
- `ex_valid`, `mem_valid`  in  1  write-back request.
- `ex_addr`, `mem_addr`  in  REG_COUNT_L2  destination register.
- `ex_value`, `mem_value`  in  BIT_WIDTH  write data.
- `ex_ready`, `mem_ready`  out  1  grant; the request is consumed this cycle.
- `write_enable1`  out  1  registered write strobe to the register file.
- `write_addr1`  out  REG_COUNT_L2  registered write address.
- `write_value1`  out  BIT_WIDTH  registered write data.
- `busy`  out  1  any pending bit set.

## Operation
- Arbitration:
  - `prio` is a 1-bit state: 0 = mem favoured, 1 = ex favoured.
  - Only one valid requester: it is granted.
  - Both valid: the favoured requester is granted.
  - On every grant, `prio` switches to favour the requester that was not granted.
  - Neither valid: no grant, `prio` holds.
- Ready rules:
  - `ex_ready` and `mem_ready` are combinational functions of the valids and `prio`, and are mutually exclusive.
  - A requester must hold `addr`/`value` stable while `valid` is high and `ready` is low.
  - Requesters must not make `valid` depend on `ready`.
- Write port: a grant in cycle N produces `write_enable1=1` in cycle N+1 with the granted addr/value. With no grant, `write_enable1=0` and addr/value hold their last values. Writes to the PC index pass through unchanged.
- Scoreboard: `pending` is a vector of REG_COUNT bits; the PC bit is hard-wired to 0.
  - Set: `issue_valid && issue_ready && !flush` sets `pending[issue_addr]` at the edge.
  - Clear: a grant to address A clears `pending[A]` at the same edge. A grant to a non-pending register is legal and leaves the scoreboard unchanged.
  - Issue and grant in the same cycle on different registers: both take effect.
  - Issue and grant in the same cycle on the same register cannot occur, because `issue_ready` is 0 while the register is pending.
  - `flush` clears all pending bits and drops any same-cycle issue. It does not cancel grants or an in-flight `write_enable1`.
- Hazard: `chk_hazard = pending[chk_addr1] | pending[chk_addr2]`, evaluated on current state with no same-cycle clear bypass. Forwarding belongs elsewhere.

## Timing
- Reset state (asynchronous): `write_enable1=0`, `write_addr1=0`, `write_value1=0`, `pending=0`, `prio=0` (mem favoured).
- Combinational outputs while in reset: `busy=0`, `chk_hazard=0`, `issue_ready=1`. Readies follow the valids.
- Reset asserted mid-operation discards any queued write: `write_enable1` drops immediately and no write is emitted after release.
- Latency: request-to-write-strobe is 1 cycle. Grant-to-pending-clear is 1 edge, so `chk_hazard` falls in the same cycle `write_enable1` rises.
- Issue-to-hazard: `chk_hazard` on the issued register rises the cycle after issue.
- Throughput: one write per cycle. Under continuous contention each requester gets 1 grant per 2 cycles.

## Structure
- `cpu/constants.svh` already supplies `BIT_WIDTH`, `REG_COUNT_L2`, `REG_COUNT` and `REG_PC_INDEX`. Add `WB_SRC_MEM=1'b0` and `WB_SRC_EX=1'b1` for the `prio` encoding.
- Sub-module `rr_arbiter2` holds the two-input round-robin arbiter with its `prio` flop; its outputs are the grant vector.
- The scoreboard and output registers stay in `regfile_wb_sched`.

## Test plan
- Reset, then `ex_valid` and `mem_valid` both high for 4 cycles with distinct addrs -> grants mem, ex, mem, ex; `write_enable1` high in cycles 2-5 with matching addr/value.
- Issue r3, next cycle check r3 -> `chk_hazard=1` and `issue_ready=0` for r3. Then `ex` writes r3=0xDEADBEEF -> `write_enable1`/`write_addr1=3`/`write_value1=0xDEADBEEF` the next cycle, with `chk_hazard=0` in that same cycle.
- Issue r15 -> `busy` stays 0 and `chk_hazard` stays 0. An `ex` write to r15 still appears on the write port.
- Issue r1, r2, r4, then `flush` together with `issue_valid` for r5 -> `busy=0` next cycle, r5 not pending, and a grant issued that same cycle still emits its write.
- Assert `reset` in the cycle after a grant -> `write_enable1` falls immediately. After release, `prio` favours mem and there are no spurious writes.
- Hold `ex_valid` with `mem_valid` low for 3 cycles -> 3 consecutive ex grants and 3 consecutive writes.
